// File: rtl/data_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_access_unit
// Description : Initiator side of the data-memory interface. Takes one
//               load/store per transaction from the datapath and drives a
//               word-addressed RAM (async read, synchronous write). Adds
//               byte/halfword loads with sign/zero extension, sub-word stores
//               by read-modify-write, and misalignment detection.
//               Little-endian: byte 0 = bits [7:0].
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_access_unit #(
    parameter logic [31:0] RESET_RDATA = 32'h0,
    parameter int          CHECK_ALIGN = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] c_OP_LW  = 3'b000;
    localparam logic [2:0] c_OP_LH  = 3'b001;
    localparam logic [2:0] c_OP_LHU = 3'b010;
    localparam logic [2:0] c_OP_LB  = 3'b011;
    localparam logic [2:0] c_OP_LBU = 3'b100;
    localparam logic [2:0] c_OP_SW  = 3'b101;
    localparam logic [2:0] c_OP_SH  = 3'b110;
    localparam logic [2:0] c_OP_SB  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WRITE  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_op;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_wbuf;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_is_load;
    logic        w_is_sub_store;
    logic        w_mis;
    logic [15:0] w_half;
    logic [7:0]  w_byte;
    logic [31:0] w_load_val;
    logic [31:0] w_merge;

    // Decode the latched request: class, misalignment, load lane and merge word
    always_comb begin
        w_is_load      = (r_op <= c_OP_LBU);
        w_is_sub_store = (r_op == c_OP_SH) || (r_op == c_OP_SB);
        w_mis          = 1'b0;
        if (CHECK_ALIGN != 0) begin
            case (r_op)
                c_OP_LW, c_OP_SW:           w_mis = (r_addr[1:0] != 2'b00);
                c_OP_LH, c_OP_LHU, c_OP_SH: w_mis = r_addr[0];
                default:                    w_mis = 1'b0;
            endcase
        end
        // Low address bits beyond the natural alignment are simply ignored
        // here, which gives truncation when alignment checking is disabled.
        w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_addr[1:0])
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        case (r_op)
            c_OP_LH:  w_load_val = {{16{w_half[15]}}, w_half};
            c_OP_LHU: w_load_val = {16'h0000, w_half};
            c_OP_LB:  w_load_val = {{24{w_byte[7]}}, w_byte};
            c_OP_LBU: w_load_val = {24'h000000, w_byte};
            default:  w_load_val = mem_rdata;
        endcase
        w_merge = mem_rdata;
        if (r_op == c_OP_SH) begin
            if (r_addr[1]) w_merge[31:16] = r_wdata[15:0];
            else           w_merge[15:0]  = r_wdata[15:0];
        end else begin
            case (r_addr[1:0])
                2'd0:    w_merge[7:0]   = r_wdata[7:0];
                2'd1:    w_merge[15:8]  = r_wdata[7:0];
                2'd2:    w_merge[23:16] = r_wdata[7:0];
                default: w_merge[31:24] = r_wdata[7:0];
            endcase
        end
    end

    // State register; reset aborts any transaction immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state and memory-port decode; mem_we follows state so it drops with reset
    always_comb begin
        w_next    = r_state;
        ready     = 1'b0;
        done      = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = 32'h0;
        mem_addr  = {r_addr[31:2], 2'b00};
        case (r_state)
            S_IDLE: begin
                ready    = 1'b1;
                mem_addr = 32'h0;
                if (req) w_next = S_ACCESS;
            end
            S_ACCESS: begin
                if (w_mis) begin
                    w_next = S_DONE;
                end else if (w_is_sub_store) begin
                    w_next = S_WRITE;
                end else begin
                    w_next = S_DONE;
                    if (r_op == c_OP_SW) begin
                        mem_we    = 1'b1;
                        mem_wdata = r_wdata;
                    end
                end
            end
            S_WRITE: begin
                mem_we    = 1'b1;
                mem_wdata = r_wbuf;
                w_next    = S_DONE;
            end
            default: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
        endcase
    end

    // Request latches, read-modify-write buffer and the held load/err results
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op    <= 3'b000;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_wbuf  <= 32'h0;
            r_rdata <= RESET_RDATA;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_op    <= op;
                        r_addr  <= addr;
                        r_wdata <= wdata;
                    end
                end
                S_ACCESS: begin
                    // err is set here so it is already valid while done is high
                    r_err <= w_mis;
                    if (!w_mis && w_is_load)      r_rdata <= w_load_val;
                    if (!w_mis && w_is_sub_store) r_wbuf  <= w_merge;
                end
                default: ;
            endcase
        end
    end

    assign rdata = r_rdata;
    assign err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_access_unit
// Description : Directed self-checking bench for data_mem_access_unit with a
//               small word-addressed RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    logic [31:0] ram [0:63];

    int n_checks = 0;
    int n_pass   = 0;

    data_mem_access_unit dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .op        (op),
        .addr      (addr),
        .wdata     (wdata),
        .ready     (ready),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // RAM model: asynchronous read, write on rising edge
    assign mem_rdata = ram[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr[7:2]] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else             n_pass++;
    endtask

    // Issue one request from IDLE; report latency, write-enable cycles and results at done
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                         output int lat, output int we_cnt,
                         output logic [31:0] rd, output logic er);
        lat    = 0;
        we_cnt = 0;
        rd     = 32'hx;
        er     = 1'bx;
        @(negedge clk);
        op = o; addr = a; wdata = d; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        op = 3'b000; addr = 32'hFFFF_FFFF; wdata = 32'hFFFF_FFFF;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (mem_we) we_cnt++;
            if (done) begin
                lat = i;
                rd  = rdata;
                er  = err;
                break;
            end
        end
    endtask

    int          lat;
    int          wec;
    logic [31:0] rd;
    logic        er;
    int          n_done;
    int          n_busy;
    int          n_both;

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 32'h0;
        ram[20] = 32'h0000_00A3;   // 0x50
        ram[21] = 32'h0000_0027;   // 0x54
        reset = 1'b1; req = 1'b0; op = 3'b000; addr = 32'h0; wdata = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_ready",     {31'h0, ready},  32'h1);
        check("rst_done",      {31'h0, done},   32'h0);
        check("rst_err",       {31'h0, err},    32'h0);
        check("rst_rdata",     rdata,           32'h0);
        check("rst_mem_we",    {31'h0, mem_we}, 32'h0);
        check("rst_mem_addr",  mem_addr,        32'h0);
        check("rst_mem_wdata", mem_wdata,       32'h0);
        reset = 1'b0;

        // Signed and unsigned byte loads
        do_op(3'b011, 32'h50, 32'h0, lat, wec, rd, er);
        check("lb_lat",   lat, 2);
        check("lb_rdata", rd,  32'hFFFF_FFA3);
        check("lb_err",   {31'h0, er}, 32'h0);
        do_op(3'b100, 32'h50, 32'h0, lat, wec, rd, er);
        check("lbu_rdata", rd, 32'h0000_00A3);

        // Byte store by read-modify-write
        do_op(3'b111, 32'h55, 32'h0000_005A, lat, wec, rd, er);
        check("sb_lat",   lat, 3);
        check("sb_we",    wec, 1);
        check("sb_ram",   ram[21], 32'h0000_5A27);
        check("sb_rdata_held", rd, 32'h0000_00A3);

        // Misaligned halfword store is rejected
        do_op(3'b110, 32'h51, 32'h0000_1234, lat, wec, rd, er);
        check("sh_mis_lat", lat, 2);
        check("sh_mis_err", {31'h0, er}, 32'h1);
        check("sh_mis_we",  wec, 0);
        check("sh_mis_ram", ram[20], 32'h0000_00A3);

        // Word store, then halfword/byte loads of each lane
        do_op(3'b101, 32'h58, 32'hDEAD_BEEF, lat, wec, rd, er);
        check("sw_lat", lat, 2);
        check("sw_we",  wec, 1);
        check("sw_err_cleared", {31'h0, er}, 32'h0);
        check("sw_ram", ram[22], 32'hDEAD_BEEF);
        do_op(3'b001, 32'h5A, 32'h0, lat, wec, rd, er);
        check("lh_hi", rd, 32'hFFFF_DEAD);
        do_op(3'b010, 32'h58, 32'h0, lat, wec, rd, er);
        check("lhu_lo", rd, 32'h0000_BEEF);
        do_op(3'b011, 32'h5B, 32'h0, lat, wec, rd, er);
        check("lb_b3", rd, 32'hFFFF_FFDE);
        do_op(3'b100, 32'h59, 32'h0, lat, wec, rd, er);
        check("lbu_b1", rd, 32'h0000_00BE);
        do_op(3'b000, 32'h54, 32'h0, lat, wec, rd, er);
        check("lw", rd, 32'h0000_5A27);

        // Halfword store to upper lane
        do_op(3'b110, 32'h5A, 32'h0000_1234, lat, wec, rd, er);
        check("sh_ram", ram[22], 32'h1234_BEEF);

        // Misaligned word load keeps previous rdata
        do_op(3'b000, 32'h52, 32'h0, lat, wec, rd, er);
        check("lw_mis_err",   {31'h0, er}, 32'h1);
        check("lw_mis_rdata", rd, 32'h0000_5A27);

        // Reset asserted during the WRITE cycle of a byte store
        @(negedge clk);
        op = 3'b111; addr = 32'h50; wdata = 32'h11; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);            // ACCESS
        @(negedge clk);            // WRITE
        check("rmw_we_before", {31'h0, mem_we}, 32'h1);
        reset = 1'b1;
        #1;
        check("rst_mid_we",    {31'h0, mem_we}, 32'h0);
        check("rst_mid_ready", {31'h0, ready},  32'h1);
        check("rst_mid_done",  {31'h0, done},   32'h0);
        @(negedge clk);
        reset = 1'b0;
        n_done = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("rst_mid_no_done", n_done, 0);
        check("rst_mid_ram",     ram[20], 32'h0000_00A3);

        // req held high: one done per three-cycle transaction
        @(negedge clk);
        op = 3'b000; addr = 32'h50; wdata = 32'h0; req = 1'b1;
        n_done = 0; n_busy = 0; n_both = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (!ready) n_busy++;
            if (done && ready) n_both++;
            if (done) begin
                n_done++;
                check("cont_rdata", rdata, 32'h0000_00A3);
            end
        end
        req = 1'b0;
        check("cont_dones", n_done, 3);
        check("cont_busy",  n_busy, 6);
        check("cont_overlap", n_both, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Absolute time limit so the bench always ends
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
